// File: rtl/four_bit_accumulator.sv
// Four-bit signed accumulator with a handshaked command port. The adder result
// is given SETTLE_CYCLES extra cycles before it is captured, along with C/V/Z flags.

module four_bit_adder_subtractor (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Op,
  output logic [3:0] S,
  output logic       Cout
);
  logic [3:0] w_b;
  logic [4:0] w_sum;

  // Subtraction is A + ~B + 1, so Cout=1 means no borrow.
  assign w_b   = B ^ {4{Op}};
  assign w_sum = {1'b0, A} + {1'b0, w_b} + {4'b0000, Op};
  assign S     = w_sum[3:0];
  assign Cout  = w_sum[4];
endmodule

// state  | meaning
// IDLE   | cmd_ready=1, waiting for a command
// SETTLE | operand latched, adder settling; captures when the timer reaches 0
// DONE   | res_valid=1, result held until res_ack
module four_bit_accumulator #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [3:0] cmd_data,
  output logic [3:0] acc,
  output logic       res_valid,
  input  logic       res_ack,
  output logic       flag_c,
  output logic       flag_v,
  output logic       flag_z,
  output logic [7:0] op_count
);
  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("four_bit_accumulator: SETTLE_CYCLES=%0d is outside 1..15", SETTLE_CYCLES);
  end

  localparam logic [3:0] LP_SETTLE = 4'(SETTLE_CYCLES);
  localparam logic [1:0] OP_LOAD   = 2'b00;
  localparam logic [1:0] OP_ADD    = 2'b01;
  localparam logic [1:0] OP_SUB    = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_DONE} state_t;

  state_t     r_state, w_next;
  logic [1:0] r_op;
  logic [3:0] r_operand;
  logic [3:0] r_cnt;
  logic [3:0] r_acc;
  logic       r_c, r_v, r_z;
  logic [7:0] r_count;

  logic [3:0] w_sum;
  logic       w_cout;
  logic       w_sub;
  logic       w_settle_done;
  logic [3:0] w_res;
  logic       w_c, w_v;

  assign w_sub         = (r_op == OP_SUB);
  assign w_settle_done = (r_state == S_SETTLE) && (r_cnt == 4'd0);

  four_bit_adder_subtractor u_addsub (
    .A    (r_acc),
    .B    (r_operand),
    .Op   (w_sub),
    .S    (w_sum),
    .Cout (w_cout)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (cmd_valid) w_next = S_SETTLE;
      S_SETTLE: if (r_cnt == 4'd0) w_next = S_DONE;
      S_DONE:   if (res_ack) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    res_valid = 1'b0;
    case (r_state)
      S_IDLE:  cmd_ready = 1'b1;
      S_DONE:  res_valid = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    w_res = 4'd0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (r_op)
      OP_LOAD: w_res = r_operand;
      OP_ADD: begin
        w_res = w_sum;
        w_c   = w_cout;
        w_v   = (r_acc[3] == r_operand[3]) && (w_sum[3] != r_acc[3]);
      end
      OP_SUB: begin
        w_res = w_sum;
        w_c   = w_cout;
        w_v   = (r_acc[3] != r_operand[3]) && (w_sum[3] != r_acc[3]);
      end
      default: ;
    endcase
  end

  // Timer is loaded with SETTLE_CYCLES on accept, so capture lands SETTLE_CYCLES+1 edges later.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op      <= 2'b00;
      r_operand <= 4'd0;
      r_cnt     <= 4'd0;
      r_acc     <= 4'd0;
      r_c       <= 1'b0;
      r_v       <= 1'b0;
      r_z       <= 1'b0;
      r_count   <= 8'd0;
    end else begin
      if (r_state == S_IDLE && cmd_valid) begin
        r_op      <= cmd_op;
        r_operand <= cmd_data;
        r_cnt     <= LP_SETTLE;
      end else if (r_state == S_SETTLE && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_settle_done) begin
        r_acc   <= w_res;
        r_c     <= w_c;
        r_v     <= w_v;
        r_z     <= (w_res == 4'd0);
        r_count <= r_count + 8'd1;
      end
    end
  end

  assign acc      = r_acc;
  assign flag_c   = r_c;
  assign flag_v   = r_v;
  assign flag_z   = r_z;
  assign op_count = r_count;
endmodule
